// File: rtl/rs_dec_pkg.sv
// Shared RS(544,514) decoder definitions: symbol width, default delay-buffer
// depth and the FIFO status bundle.
package rs_dec_pkg;

  localparam int unsigned SYM_W   = 10;
  localparam int unsigned FIFO_AW = 4;

  typedef struct packed {
    logic [FIFO_AW:0] count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Two-port symbol storage: clocked write port, combinational read port.
// Contents are never cleared; writes are suppressed while in reset.
module sync_fifo_ram
  import rs_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_AW,
  parameter int unsigned DATA_WIDTH = SYM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[addr_in] <= data_in;
    end
  end

  assign data_out = mem[addr_out];

endmodule

// File: rtl/rs_fifo_ctrl.sv
// Pointer / flow-control sequencer for the Chien/Forney symbol delay buffer.
// First-word-fall-through FIFO around sync_fifo_ram with valid/ready on both
// sides, occupancy count, status flags and sticky error flags.
module rs_fifo_ctrl
  import rs_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FIFO_AW,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned AFULL_THRESH = (2**ADDR_WIDTH) - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE    = 1;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_q;
  logic                overflow_q;
  logic                underflow_q;
  logic                push;
  logic                pop;
  logic                ram_wr_en;

  // Flags come from registered pointers/count only, so ready/valid never
  // depend combinationally on the handshake inputs.
  always_comb begin
    empty_o       = (wr_ptr == rd_ptr);
    full_o        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    almost_full_o = (count_q >= AFULL_LVL);
    in_ready_o    = ~full_o;
    out_valid_o   = ~empty_o;
    push          = in_valid_i & in_ready_o;
    pop           = out_ready_i & out_valid_o;
    ram_wr_en     = push & ~flush_i;
  end

  // Pointer, occupancy and sticky-error state; flush overrides any handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
      if (in_valid_i && full_o)   overflow_q  <= 1'b1;
      if (out_ready_i && empty_o) underflow_q <= 1'b1;
    end
  end

  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  sync_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk      (clk_i),
    .rst_n    (~rst_i),
    .wr_en    (ram_wr_en),
    .addr_in  (wr_ptr[ADDR_WIDTH-1:0]),
    .data_in  (in_data_i),
    .addr_out (rd_ptr[ADDR_WIDTH-1:0]),
    .data_out (out_data_o)
  );

endmodule

// File: tb/tb_rs_fifo_ctrl.sv
// Self-checking bench for rs_fifo_ctrl against a queue-based reference model.
module tb_rs_fifo_ctrl;
  import rs_dec_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [4:0]  count;
  logic        empty, full, afull, ovf, unf;

  int tests_run = 0;
  int fails = 0;

  logic [15:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  fifo_status_t act;
  assign act = {count, empty, full, afull, ovf, unf};

  rs_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .AFULL_THRESH(14)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_ready_i   (out_ready),
    .count_o       (count),
    .empty_o       (empty),
    .full_o        (full),
    .almost_full_o (afull),
    .overflow_o    (ovf),
    .underflow_o   (unf)
  );

  always #5 clk = ~clk;

  function automatic fifo_status_t exp_status();
    fifo_status_t s;
    s.count       = 5'(q.size());
    s.empty       = (q.size() == 0);
    s.full        = (q.size() == DEPTH);
    s.almost_full = (q.size() >= DEPTH - 2);
    s.overflow    = m_ovf;
    s.underflow   = m_unf;
    return s;
  endfunction

  // One clock with the given inputs; model advances by the FIFO's rules.
  task automatic cycle(input bit v, input logic [15:0] d, input bit r, input bit f);
    int n;
    bit pu, po;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    n  = q.size();
    pu = v && (n < DEPTH) && !f;
    po = r && (n > 0) && !f;
    @(posedge clk); #1;
    if (f) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (v && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (act !== exp_status() || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: status=%h valid=%b ready=%b expected status=%h valid=0 ready=1",
               act, out_valid, in_ready, exp_status());
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      tests_run++;
      if (act !== exp_status() || count !== 5'(i) || afull !== (i >= 14)) begin
        fails++;
        $display("FAIL fill_step%0d: status=%h expected %h (count %0d)", i, act, exp_status(), i);
      end
    end
    tests_run++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: full=%b ready=%b expected 1/0", full, in_ready);
    end
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    tests_run++;
    if (ovf !== 1'b1 || count !== 5'd16 || act !== exp_status()) begin
      fails++;
      $display("FAIL overflow_set: ovf=%b count=%0d expected 1/16", ovf, count);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 16; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        fails++;
        $display("FAIL drain_word%0d: valid=%b data=%h expected 1/%h", i, out_valid, out_data, 16'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    tests_run++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || act !== exp_status()) begin
      fails++;
      $display("FAIL drain_empty: status=%h expected %h", act, exp_status());
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (unf !== 1'b1 || act !== exp_status()) begin
      fails++;
      $display("FAIL underflow_set: status=%h expected %h", act, exp_status());
    end
  endtask

  task automatic test_concurrent();
    logic [15:0] d;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      tests_run++;
      if (out_data !== q[0]) begin
        fails++;
        $display("FAIL concurrent_data%0d: got %h expected %h", i, out_data, q[0]);
      end
      cycle(1'b1, d, 1'b1, 1'b0);
      tests_run++;
      if (count !== 5'd5 || act !== exp_status()) begin
        fails++;
        $display("FAIL concurrent_count%0d: status=%h expected %h", i, act, exp_status());
      end
    end
    while (q.size() > 0) begin
      tests_run++;
      if (out_data !== q[0]) begin
        fails++;
        $display("FAIL concurrent_tail: got %h expected %h", out_data, q[0]);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_empty_pushthrough();
    in_valid = 1'b1; in_data = 16'hABCD;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pushthrough_same_cycle: valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin
      fails++;
      $display("FAIL pushthrough_next: valid=%b data=%h expected 1/abcd", out_valid, out_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    tests_run++;
    if (count !== 5'd15 || full !== 1'b0 || act !== exp_status()) begin
      fails++;
      $display("FAIL full_pushpop: status=%h expected %h (count 15)", act, exp_status());
    end
    while (q.size() > 0) begin
      tests_run++;
      if (out_data !== q[0]) begin
        fails++;
        $display("FAIL full_pushpop_order: got %h expected %h", out_data, q[0]);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (count !== 5'd9 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL flush_setup: count=%0d ovf=%b expected 9/1", count, ovf);
    end
    cycle(1'b1, 16'h1234, 1'b1, 1'b1);
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0 || act !== exp_status()) begin
      fails++;
      $display("FAIL flush_clear: status=%h expected %h", act, exp_status());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    tests_run++;
    if (act !== exp_status() || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: status=%h valid=%b ready=%b expected %h/0/1",
               act, out_valid, in_ready, exp_status());
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit v, r, f;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 59) == 0);
      if (q.size() > 0) begin
        tests_run++;
        if (out_data !== q[0]) begin
          fails++;
          $display("FAIL random_data%0d: got %h expected %h", i, out_data, q[0]);
        end
      end
      cycle(v, 16'($urandom), r, f);
      tests_run++;
      if (act !== exp_status() || out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)) begin
        fails++;
        $display("FAIL random_status%0d: status=%h valid=%b ready=%b expected %h",
                 i, act, out_valid, in_ready, exp_status());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_concurrent();
    test_empty_pushthrough();
    test_full_pushpop();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/rs_fifo_ctrl.md
# rs_fifo_ctrl

Pointer and flow-control sequencer for the Chien/Forney symbol delay buffer in the RS(544,514) decoder. It wraps the team's `sync_fifo_ram` 2-port storage, which has a clocked write and a combinational read. It owns the write/read pointers, occupancy count, full/empty/almost-full flags and sticky error flags. It presents valid/ready handshakes on both sides: received symbols are written in while syndrome/BM run, and drained in order to the error-correction adder.

## Interface
- `ADDR_WIDTH`, 4: RAM address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 16: symbol word width.
- `AFULL_THRESH`, `DEPTH-2`: occupancy at or above which `almost_full` asserts.
- `clk_i` in 1: single clock; all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: synchronous clear of pointers, count and error flags; highest priority.
- `in_valid_i` in 1: write request.
- `in_data_i` in DATA_WIDTH: write data.
- `in_ready_o` out 1: space available.
- `out_valid_o` out 1: read data available.
- `out_data_o` out DATA_WIDTH: head-of-FIFO word (first-word-fall-through).
- `out_ready_i` in 1: consumer accepts head word.
- `count_o` out ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `empty_o`, `full_o`, `almost_full_o` out 1: status flags.
- `overflow_o`, `underflow_o` out 1: sticky error flags.

## Operation
- Pointers `wr_ptr`/`rd_ptr` are ADDR_WIDTH+1 bits: low bits address the RAM, MSB is the wrap bit.
- Empty: pointers fully equal. Full: low bits equal and wrap bits differ.
- `count_o` is a registered counter (+1 push, −1 pop, unchanged on both or neither) and must always equal `wr_ptr - rd_ptr` mod 2^(ADDR_WIDTH+1).
- Push: `in_valid_i & in_ready_o`, with `in_ready_o = ~full_o`. Drives RAM `wr_en=1`, `addr_in=wr_ptr[ADDR_WIDTH-1:0]`; `wr_ptr` increments.
- Pop: `out_valid_o & out_ready_i`, with `out_valid_o = ~empty_o`. `rd_ptr` increments.
- RAM `addr_out = rd_ptr[ADDR_WIDTH-1:0]`; `out_data_o` = RAM `data_out`, combinational.
- Simultaneous push and pop: both pointers advance, count is unchanged. Legal at any non-empty, non-full occupancy.
- When full: a pop is accepted, but the push in the same cycle is refused because `in_ready_o=0`. There is no write-through when full.
- When empty: no pop is possible, and a same-cycle push is not visible on the output until the next cycle.
- `overflow_o` sets on `in_valid_i & full_o`. `underflow_o` sets on `out_ready_i & empty_o & out_valid_i`-style misuse, defined as `out_ready_i` asserted while empty. Both clear only on reset or `flush_i`.
- `flush_i`: next edge sets pointers and count to 0 and clears the error flags. Any push or pop in that cycle is discarded. RAM contents are not cleared.
- Wrap-around: the low pointer bits roll from DEPTH-1 to 0 and the wrap bit toggles.

## Timing
- Reset values: `count_o=0`, `empty_o=1`, `full_o=0`, `almost_full_o=0`, `out_valid_o=0`, `in_ready_o=1`, `overflow_o=0`, `underflow_o=0`, pointers 0.
- The RAM reset input is driven as `~rst_i`.
- Write-to-read latency is 1 cycle: a push at edge N makes `out_valid_o=1` with that word valid after edge N. Data is read combinationally from the RAM in the same cycle as the pop.
- Flags are registered or derived from registered pointers only. There is no combinational path from `in_valid_i`/`out_ready_i` to `in_ready_o`/`out_valid_o`.
- Reset asserted mid-stream: all state returns to reset values immediately, with no clock required.

## Structure
- Shared package `rs_dec_pkg`: `SYM_W=10`, the default `FIFO_AW`, and the `fifo_status_t` struct (count, empty, full, almost_full, overflow, underflow).
- Sub-module: one `sync_fifo_ram` instance (ADDR_WIDTH, DATA_WIDTH passed through).
- Pointer, count and flag logic live in this block.

## Test plan
- Reset, then 16 pushes of 0x0001..0x0010 (ADDR_WIDTH=4) → `full_o=1` after the 16th edge, `count_o=16`, `almost_full_o=1` from count 14. A 17th push with `in_valid_i=1` sets `overflow_o`, and the data is dropped.
- Drain all 16 → `out_data_o` sequence 0x0001..0x0010, `empty_o=1`. An extra `out_ready_i` sets `underflow_o`.
- Steady concurrent push/pop at count 5 for 40 cycles → count stays 5, pointers wrap twice, data order preserved.
- Push 0xABCD into an empty FIFO → `out_valid_o=0` in the push cycle, `out_data_o=0xABCD` and `out_valid_o=1` the next cycle.
- Full FIFO with push and pop asserted together → the pop is accepted, the push is refused, and `count_o=15`.
- `flush_i` at count 9 with overflow set → next cycle `count_o=0`, `empty_o=1`, `overflow_o=0`. Async `rst_i` mid-stream gives the reset values immediately.
